// File: rtl/csa_resolve.sv
// Sequential carry-save to binary resolver: one CHUNK-bit ripple add per clock.
// Optional feature macro: CSA_RESOLVE_BYPASS_EN (DONE hands off directly to a new accept).
module csa_resolve #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_ovf
);

    localparam int unsigned K    = WIDTH / CHUNK;
    localparam int unsigned IDXW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic [IDXW-1:0]  idx;
    logic             carry, dropped;
    logic             accept, last_chunk, ready_raw;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] chunk_ext, res_next;

    assign accept     = in_valid && in_ready;
    assign last_chunk = (idx == IDXW'(K - 1));

    // Operands shift right each cycle so the active chunk is always the low CHUNK bits;
    // results enter from the top, leaving the word aligned after K chunks.
    always_comb begin
        chunk_sum = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        chunk_ext = WIDTH'(chunk_sum[CHUNK-1:0]);
        res_next  = (res_reg >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = ADD;
            ADD:  if (last_chunk) state_next = DONE;
            DONE: begin
                if (out_ready) begin
`ifdef CSA_RESOLVE_BYPASS_EN
                    state_next = accept ? ADD : IDLE;
`else
                    state_next = IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_raw = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: ready_raw = 1'b1;
            DONE: begin
                out_valid = 1'b1;
`ifdef CSA_RESOLVE_BYPASS_EN
                ready_raw = out_ready;
`endif
            end
            default: ready_raw = 1'b0;
        endcase
        in_ready = ready_raw && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            idx        <= '0;
            carry      <= 1'b0;
            dropped    <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
        end else if (accept) begin
            a_reg   <= in_sum;
            b_reg   <= {in_carry[WIDTH-2:0], 1'b0};
            dropped <= in_carry[WIDTH-1];
            idx     <= '0;
            carry   <= 1'b0;
        end else if (state == ADD) begin
            a_reg   <= a_reg >> CHUNK;
            b_reg   <= b_reg >> CHUNK;
            res_reg <= res_next;
            carry   <= chunk_sum[CHUNK];
            idx     <= idx + IDXW'(1);
            if (last_chunk) begin
                out_result <= res_next;
                out_ovf    <= chunk_sum[CHUNK] | dropped;
            end
        end
    end

endmodule

// File: tb/tb_csa_resolve.sv
// Directed and random self-checking bench for csa_resolve (default 16/4 geometry).
module tb_csa_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sum;
    logic [15:0] in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    csa_resolve #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts one pair and waits (bounded) for out_valid; leaves the result unconsumed.
    task automatic load_and_wait(input logic [15:0] s, input logic [15:0] c, output bit ok);
        in_sum = s; in_carry = c; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; in_carry = '0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_result !== 16'h0000) begin errors++; $display("FAIL reset_out_result got %h want 0000", out_result); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        in_sum = 16'h1234; in_carry = 16'h0001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (out_valid !== (i == 4)) begin
                errors++; $display("FAIL basic_latency edge %0d got %b want %b", i, out_valid, (i == 4));
            end
        end
        checks++; if (out_result !== 16'h1236) begin errors++; $display("FAIL basic_result got %h want 1236", out_result); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", out_ovf); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_release got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready got %b want 1", in_ready); end
    endtask

    task automatic test_wrap();
        logic [15:0] s_tab [2] = '{16'hFFFF, 16'h0000};
        logic [15:0] c_tab [2] = '{16'h0001, 16'h8000};
        logic [15:0] r_tab [2] = '{16'h0001, 16'h0000};
        bit ok;
        for (int i = 0; i < 2; i++) begin
            load_and_wait(s_tab[i], c_tab[i], ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL wrap_timeout case %0d got no out_valid want out_valid", i); end
            checks++;
            if (out_result !== r_tab[i]) begin errors++; $display("FAIL wrap_result case %0d got %h want %h", i, out_result, r_tab[i]); end
            checks++;
            if (out_ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf case %0d got %b want 1", i, out_ovf); end
            out_ready = 1'b1; step(); out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        load_and_wait(16'h0F0F, 16'h0808, ok); // 0x0F0F + 0x1010 = 0x1F1F
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got no out_valid want out_valid"); end
        in_sum = 16'hAAAA; in_carry = 16'h0055; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 16'h1F1F || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b r=%h o=%b ir=%b want v=1 r=1f1f o=0 ir=0",
                         i, out_valid, out_result, out_ovf, in_ready);
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_add();
        in_sum = 16'h7777; in_carry = 16'h1111; in_valid = 1'b1;
        step();              // E0 accept
        in_valid = 1'b0;
        step(); step();      // E1, E2: chunks 0 and 1 done, chunk 2 next
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready_during got %b want 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state got v=%b r=%h o=%b ir=%b want v=0 r=0000 o=0 ir=1",
                     out_valid, out_result, out_ovf, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_emit cycle %0d got 1 want 0", i); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] exp_r [$];
        logic        exp_o [$];
        logic [17:0] total;
        logic [15:0] er;
        logic        eo;
        int sent = 0, recv = 0, budget = 40000;
        bit acc;
        in_valid = 1'b0;
        while (recv < 1000 && budget > 0) begin
            budget--;
            if (!in_valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
                in_sum = 16'($urandom); in_carry = 16'($urandom);
                if ($urandom_range(0, 7) == 0) in_sum = 16'hFFFF;
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_valid && in_ready;
            if (acc) begin
                total = {2'b00, in_sum} + {1'b0, in_carry, 1'b0};
                exp_r.push_back(total[15:0]);
                exp_o.push_back(total[17:16] != 2'b00);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_r.size() == 0) begin
                    errors++; $display("FAIL rand_spurious got result %h want none", out_result);
                end else begin
                    er = exp_r.pop_front(); eo = exp_o.pop_front();
                    if (out_result !== er || out_ovf !== eo) begin
                        errors++;
                        $display("FAIL rand_result #%0d got %h/%b want %h/%b", recv, out_result, out_ovf, er, eo);
                    end
                end
                recv++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (recv != 1000 || sent != 1000) begin
            errors++; $display("FAIL rand_count got sent=%0d recv=%0d want 1000/1000", sent, recv);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s_tab [4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h00FF};
        logic [15:0] c_tab [4] = '{16'h0001, 16'h0001, 16'h8000, 16'h0080};
        logic [15:0] r_tab [4] = '{16'h1236, 16'h0001, 16'h0000, 16'h01FF};
        logic        o_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int acc_cyc [4];
        int tx = 0, rx = 0;
        int gap;
        bit acc;
`ifdef CSA_RESOLVE_BYPASS_EN
        gap = 5;
`else
        gap = 6;
`endif
        out_ready = 1'b1;
        for (int n = 0; n < 100 && rx < 4; n++) begin
            in_valid = (tx < 4);
            if (tx < 4) begin in_sum = s_tab[tx]; in_carry = c_tab[tx]; end
            #1;
            acc = in_valid && in_ready;
            if (acc) acc_cyc[tx] = cyc;
            if (out_valid) begin
                checks++;
                if (out_result !== r_tab[rx] || out_ovf !== o_tab[rx]) begin
                    errors++;
                    $display("FAIL b2b_result #%0d got %h/%b want %h/%b", rx, out_result, out_ovf, r_tab[rx], o_tab[rx]);
                end
                rx++;
            end
            @(posedge clk); #1;
            if (acc) tx++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (rx != 4 || tx != 4) begin
            errors++; $display("FAIL b2b_timeout got tx=%0d rx=%0d want 4/4", tx, rx);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != gap) begin
                    errors++; $display("FAIL b2b_spacing #%0d got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], gap);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid_add();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_resolve.md
# csa_resolve

Sequential carry-save-to-binary resolver for the Radix-4 Booth multiplier datapath. It sits at the output of the 4:2 compressor tree. It accepts one redundant (sum, carry) vector pair through a valid/ready handshake and resolves it into a binary result with a CHUNK-bit ripple adder, one chunk per clock. The result and an overflow flag are presented through a second valid/ready handshake.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per clock; K = WIDTH/CHUNK chunk cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept an operand pair.
- in_sum  input  WIDTH  compressor sum vector; bit i has weight 2^i.
- in_carry  input  WIDTH  compressor carry vector; bit i has weight 2^(i+1).
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result.
- out_result  output  WIDTH  (in_sum + 2*in_carry) mod 2^WIDTH.
- out_ovf  output  1  set when the true sum is 2^WIDTH or greater.

## Operation
- FSM states: IDLE, ADD, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch A=in_sum and B={in_carry[WIDTH-2:0],1'b0}.
  - Latch dropped bit D=in_carry[WIDTH-1].
  - Clear the chunk index and the carry register, then go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle, add chunk idx of A, chunk idx of B and the carry register.
  - Write the CHUNK result bits into the result register at chunk idx and update the carry register.
  - Chunks are processed LSB chunk first.
  - After chunk K-1, set out_ovf = final carry | D, load out_result and go to DONE.
- DONE:
  - out_valid=1. out_result and out_ovf are held stable until out_valid&&out_ready.
  - On that handshake, go to IDLE.
- in_valid while the block is busy is ignored, not queued. The producer must hold its data until it sees in_ready.
- out_result and out_ovf keep their last values in IDLE and ADD. Only out_valid qualifies them.
- The arithmetic is unsigned and modular. Sign handling belongs upstream in the Booth encoding.

## Timing
- Reset values:
  - state=IDLE, out_valid=0, out_result=0, out_ovf=0.
  - Chunk index=0, carry register=0.
  - in_ready=0 while rst is high and 1 in the first cycle after reset is released.
- Latency: accept at edge E0; chunks are processed at edges E1..EK; out_valid rises after EK. This gives K cycles (4 with the defaults).
- Throughput without the bypass feature: one result per K+2 cycles. The DONE→IDLE step costs one cycle.
- in_ready is combinational from the state (and from out_ready under the bypass feature). There is no combinational path from in_valid to in_ready.
- out_valid is registered.
- rst asserted in any state, including mid-ADD: the next state is IDLE with all outputs at reset values. A partial result is never emitted.
- Wrap-around:
  - in_sum=all-ones plus nonzero carry gives a modular result with out_ovf=1.
  - in_carry[WIDTH-1]=1 always sets out_ovf.

## Configuration
- CSA_RESOLVE_BYPASS_EN defined:
  - In DONE, in_ready = out_ready.
  - If out_valid&&out_ready&&in_valid, the block delivers the result and latches the new operands on the same edge, then goes straight to ADD.
  - Throughput becomes one result per K+1 cycles.
- Not defined: in_ready=0 in DONE, and DONE always returns to IDLE first.
- Latency, reset behaviour and results are identical either way.

## Test plan
- in_sum=16'h1234, in_carry=16'h0001 (defaults) → out_result=16'h1236, out_ovf=0, out_valid rising 4 cycles after the accept edge.
- in_sum=16'hFFFF, in_carry=16'h0001 → out_result=16'h0001, out_ovf=1. Also in_sum=16'h0000, in_carry=16'h8000 → out_result=16'h0000, out_ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new data → out_valid, out_result and out_ovf stay stable, in_ready=0, no new accept. Result released on the first out_ready=1 edge.
- Assert rst for one cycle while in ADD at chunk 2 → next cycle IDLE, out_valid=0, out_result=0, in_ready=1. No result is ever emitted for that operand pair.
- Random streams of 1000 pairs with random in_valid/out_ready gaps → every out_result/out_ovf matches a reference model, in order, with no drops or duplicates.
- Back-to-back operands with out_ready=1 → accepts spaced 6 cycles apart without CSA_RESOLVE_BYPASS_EN and 5 cycles apart with it, results identical in both builds.
